// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/flush/halt controls in, instruction memory port and
// IF/ID register contents out. The fetch stage uses the slave modport.
interface fetch_stage_if;
    logic        pc_write;
    logic        IF_ID_write;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] imem_data;
    logic [31:0] imem_addr;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc;
    logic        IF_ID_valid;
    logic        is_halted;
    logic [31:0] fetch_count;

    modport master (
        output pc_write,
        output IF_ID_write,
        output flush,
        output redirect_pc,
        output halt,
        output imem_data,
        input  imem_addr,
        input  IF_ID_inst,
        input  IF_ID_pc,
        input  IF_ID_valid,
        input  is_halted,
        input  fetch_count
    );

    modport slave (
        input  pc_write,
        input  IF_ID_write,
        input  flush,
        input  redirect_pc,
        input  halt,
        input  imem_data,
        output imem_addr,
        output IF_ID_inst,
        output IF_ID_pc,
        output IF_ID_valid,
        output is_halted,
        output fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, sticky halt and a
// saturating fetch counter. Priority per edge is reset > flush > halted > normal.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic        cnt_sat;

    assign pc_plus4 = pc_q + 32'd4;
    assign cnt_sat  = &cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if_pc_d = if_pc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (bus.flush) begin
            // Redirect wins over both stall and halt; the halt request is still latched.
            pc_d    = bus.redirect_pc;
            inst_d  = NOP_INST;
            if_pc_d = 32'h0;
            valid_d = 1'b0;
            if (bus.halt) begin
                state_d = StHalted;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.pc_write) begin
                        pc_d = pc_plus4;
                    end
                    if (bus.IF_ID_write) begin
                        inst_d  = bus.imem_data;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                        if (!cnt_sat) begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    if (bus.halt) begin
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: begin
                    state_d = StHalted;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            if_pc_q <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            if_pc_q <= if_pc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.IF_ID_inst  = inst_q;
    assign bus.IF_ID_pc    = if_pc_q;
    assign bus.IF_ID_valid = valid_q;
    assign bus.is_halted   = (state_q == StHalted);
    assign bus.fetch_count = cnt_q;

    a_reset_values: assert property (@(posedge clk)
        reset |=> (pc_q == RESET_PC && inst_q == NOP_INST && !valid_q && cnt_q == 32'h0
                   && state_q == StRun));

    a_halt_sticky: assert property (@(posedge clk) disable iff (reset)
        (state_q == StHalted) |=> (state_q == StHalted));

    // Only a flush may move the PC or IF/ID once halted.
    a_halt_frozen: assert property (@(posedge clk) disable iff (reset)
        (state_q == StHalted && !bus.flush) |=> ($stable(pc_q) && $stable(cnt_q)
                                                 && $stable(inst_q) && $stable(valid_q)));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected post-edge
// state; a negedge monitor pops and compares, and each scenario adds fixed-value checks.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] inst_at(input logic [31:0] a);
        return 32'h0000_000A + (a >> 2);
    endfunction

    assign bus.imem_data = inst_at(bus.imem_addr);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [31:0] m_pc, m_inst, m_ifpc, m_cnt;
    logic        m_valid, m_halted;

    // Independent reference of the fetch behaviour, advanced once per driven edge.
    task automatic cycle(input logic rst, input logic pw, input logic iw, input logic fl,
                         input logic [31:0] rpc, input logic ht);
        exp_t e;
        reset           = rst;
        bus.pc_write    = pw;
        bus.IF_ID_write = iw;
        bus.flush       = fl;
        bus.redirect_pc = rpc;
        bus.halt        = ht;
        if (rst) begin
            m_pc = 32'h0; m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
            m_halted = 1'b0; m_cnt = 32'h0;
        end else if (fl) begin
            m_pc = rpc; m_inst = NOP; m_ifpc = 32'h0; m_valid = 1'b0;
            if (ht) m_halted = 1'b1;
        end else if (!m_halted) begin
            if (iw) begin
                m_inst  = inst_at(m_pc);
                m_ifpc  = m_pc;
                m_valid = 1'b1;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
            if (pw) m_pc = m_pc + 32'd4;
            if (ht) m_halted = 1'b1;
        end
        e = '{addr: m_pc, inst: m_inst, pc: m_ifpc, valid: m_valid, halted: m_halted,
              cnt: m_cnt};
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec += 6;
            if (bus.imem_addr !== e.addr) begin
                n_miss++;
                $display("FAIL sb_imem_addr got %h want %h @%0t", bus.imem_addr, e.addr, $time);
            end
            if (bus.IF_ID_inst !== e.inst) begin
                n_miss++;
                $display("FAIL sb_inst got %h want %h @%0t", bus.IF_ID_inst, e.inst, $time);
            end
            if (bus.IF_ID_pc !== e.pc) begin
                n_miss++;
                $display("FAIL sb_if_pc got %h want %h @%0t", bus.IF_ID_pc, e.pc, $time);
            end
            if (bus.IF_ID_valid !== e.valid) begin
                n_miss++;
                $display("FAIL sb_valid got %b want %b @%0t", bus.IF_ID_valid, e.valid, $time);
            end
            if (bus.is_halted !== e.halted) begin
                n_miss++;
                $display("FAIL sb_halted got %b want %b @%0t", bus.is_halted, e.halted, $time);
            end
            if (bus.fetch_count !== e.cnt) begin
                n_miss++;
                $display("FAIL sb_count got %0d want %0d @%0t", bus.fetch_count, e.cnt, $time);
            end
        end
    end

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        n_vec += 4;
        if (bus.imem_addr !== 32'h0) begin
            n_miss++; $display("FAIL reset_pc got %h want 0", bus.imem_addr);
        end
        if (bus.IF_ID_inst !== NOP) begin
            n_miss++; $display("FAIL reset_inst got %h want %h", bus.IF_ID_inst, NOP);
        end
        if (bus.IF_ID_valid !== 1'b0 || bus.is_halted !== 1'b0) begin
            n_miss++; $display("FAIL reset_flags got v=%b h=%b want 0 0",
                               bus.IF_ID_valid, bus.is_halted);
        end
        if (bus.fetch_count !== 32'h0) begin
            n_miss++; $display("FAIL reset_count got %0d want 0", bus.fetch_count);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] want_inst[3] = '{32'hA, 32'hB, 32'hC};
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            n_vec += 2;
            if (bus.IF_ID_inst !== want_inst[i]) begin
                n_miss++; $display("FAIL seq_inst[%0d] got %h want %h", i, bus.IF_ID_inst,
                                   want_inst[i]);
            end
            if (bus.IF_ID_pc !== 32'(i * 4)) begin
                n_miss++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.IF_ID_pc, i * 4);
            end
        end
        n_vec += 2;
        if (bus.fetch_count !== 32'd3) begin
            n_miss++; $display("FAIL seq_count got %0d want 3", bus.fetch_count);
        end
        if (bus.imem_addr !== 32'd12) begin
            n_miss++; $display("FAIL seq_addr got %h want c", bus.imem_addr);
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            n_vec++;
            if (bus.imem_addr !== 32'd8 || bus.IF_ID_pc !== 32'd4 || bus.IF_ID_inst !== 32'hB
                || bus.fetch_count !== 32'd2) begin
                n_miss++; $display("FAIL stall_hold got a=%h p=%h i=%h c=%0d want 8 4 b 2",
                                   bus.imem_addr, bus.IF_ID_pc, bus.IF_ID_inst, bus.fetch_count);
            end
        end
        // Independent enables: IF/ID loads while the PC is held.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.IF_ID_pc !== 32'd8 || bus.imem_addr !== 32'd8) begin
            n_miss++; $display("FAIL stall_release got p=%h a=%h want 8 8", bus.IF_ID_pc,
                               bus.imem_addr);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_flush();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        n_vec++;
        if (bus.imem_addr !== 32'h100 || bus.IF_ID_inst !== NOP || bus.IF_ID_valid !== 1'b0
            || bus.fetch_count !== 32'd2) begin
            n_miss++; $display("FAIL flush_redirect got a=%h i=%h v=%b c=%0d want 100 13 0 2",
                               bus.imem_addr, bus.IF_ID_inst, bus.IF_ID_valid, bus.fetch_count);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.IF_ID_pc !== 32'h100 || bus.IF_ID_valid !== 1'b1 || bus.IF_ID_inst !== 32'h4A)
        begin
            n_miss++; $display("FAIL flush_refetch got p=%h v=%b i=%h want 100 1 4a",
                               bus.IF_ID_pc, bus.IF_ID_valid, bus.IF_ID_inst);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.IF_ID_pc !== 32'h102 || bus.imem_addr !== 32'h106) begin
            n_miss++; $display("FAIL flush_unaligned got p=%h a=%h want 102 106",
                               bus.IF_ID_pc, bus.imem_addr);
        end
    endtask

    task automatic test_halt();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (bus.is_halted !== 1'b1 || bus.imem_addr !== 32'h24 || bus.fetch_count !== 32'd9)
        begin
            n_miss++; $display("FAIL halt_set got h=%b a=%h c=%0d want 1 24 9",
                               bus.is_halted, bus.imem_addr, bus.fetch_count);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.imem_addr !== 32'h24 || bus.fetch_count !== 32'd9 || bus.IF_ID_pc !== 32'h20)
        begin
            n_miss++; $display("FAIL halt_frozen got a=%h c=%0d p=%h want 24 9 20",
                               bus.imem_addr, bus.fetch_count, bus.IF_ID_pc);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.imem_addr !== 32'h0 || bus.is_halted !== 1'b0) begin
            n_miss++; $display("FAIL halt_reset got a=%h h=%b want 0 0", bus.imem_addr,
                               bus.is_halted);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_vec++;
        if (bus.imem_addr !== 32'h0 || bus.IF_ID_pc !== 32'hFFFF_FFFC) begin
            n_miss++; $display("FAIL wrap got a=%h p=%h want 0 fffffffc", bus.imem_addr,
                               bus.IF_ID_pc);
        end
    endtask

    task automatic test_flush_halt();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (bus.imem_addr !== 32'h40 || bus.IF_ID_valid !== 1'b0 || bus.is_halted !== 1'b1
                || bus.fetch_count !== 32'd1) begin
                n_miss++; $display("FAIL flush_halt[%0d] got a=%h v=%b h=%b c=%0d want 40 0 1 1",
                                   i, bus.imem_addr, bus.IF_ID_valid, bus.is_halted,
                                   bus.fetch_count);
            end
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 60) == 0));
        end
        // Reset taken mid-flush with a stall pattern on the other inputs.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b0);
        n_vec++;
        if (bus.imem_addr !== 32'h0 || bus.IF_ID_valid !== 1'b0 || bus.fetch_count !== 32'h0)
        begin
            n_miss++; $display("FAIL reset_mid_flush got a=%h v=%b c=%0d want 0 0 0",
                               bus.imem_addr, bus.IF_ID_valid, bus.fetch_count);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.pc_write = 1'b0; bus.IF_ID_write = 1'b0; bus.flush = 1'b0;
        bus.redirect_pc = 32'h0; bus.halt = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_halt();
        test_wrap();
        test_flush_halt();
        test_random();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++; $display("FAIL sb_drain got %0d left want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0) placed in IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_write  input  1  from hazard detection unit; 1 = PC may update.
REQ-006 IF_ID_write  input  1  from hazard detection unit; 1 = IF/ID register may load.
REQ-007 flush  input  1  from EX stage; branch/jump mispredict, redirect fetch.
REQ-008 redirect_pc  input  32  corrected target PC, valid when flush=1.
REQ-009 halt  input  1  from writeback; ecall halt reached, stop fetching.
REQ-010 imem_data  input  32  instruction at imem_addr, combinational read, same cycle.
REQ-011 imem_addr  output  32  current PC, driven combinationally from PC register.
REQ-012 IF_ID_inst  output  32  registered instruction presented to decode and hazard unit.
REQ-013 IF_ID_pc  output  32  registered PC of IF_ID_inst.
REQ-014 IF_ID_valid  output  1  1 = IF_ID_inst is a real fetched instruction.
REQ-015 is_halted  output  1  sticky halt status.
REQ-016 fetch_count  output  32  number of instructions loaded into IF/ID since reset.

Function
REQ-017 Per-edge priority SHALL be: reset > flush > halted > normal/stall.
REQ-018 On reset: PC=RESET_PC, IF_ID_inst=NOP_INST, IF_ID_pc=0, IF_ID_valid=0, is_halted=0, fetch_count=0.
REQ-019 imem_addr SHALL equal PC with zero added latency; IF_ID_inst SHALL reflect imem_data one edge after PC presents it.
REQ-020 Normal (no flush, not halted): if pc_write=1 then PC<=PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0); else PC held.
REQ-021 Normal: if IF_ID_write=1 then IF_ID_inst<=imem_data, IF_ID_pc<=PC, IF_ID_valid<=1, fetch_count increments; else all IF/ID fields and fetch_count held.
REQ-022 pc_write and IF_ID_write SHALL act independently; no combination is illegal.
REQ-023 flush=1: PC<=redirect_pc, IF_ID_inst<=NOP_INST, IF_ID_valid<=0, IF_ID_pc<=0, fetch_count held, regardless of pc_write/IF_ID_write (flush overrides stall).
REQ-024 redirect_pc SHALL be used as-is; bits [1:0] are not masked.
REQ-025 halt=1 for one or more cycles SHALL set is_halted<=1 on that edge; is_halted stays 1 until reset.
REQ-026 While is_halted=1 (from the edge after it is set): PC, IF/ID fields and fetch_count SHALL hold regardless of pc_write/IF_ID_write.
REQ-027 flush and halt asserted on the same edge: flush update applies and is_halted is set; subsequent edges frozen.
REQ-028 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-029 All outputs except imem_addr SHALL be registered.

Reset
REQ-030 Reset asserted mid-stall, mid-flush or while halted SHALL restore all REQ-018 values on that edge, ignoring every other input.
REQ-031 First instruction SHALL be fetched at RESET_PC in the cycle after reset deasserts and appear in IF/ID on the following edge.

Verification
REQ-032 Reset, then 3 cycles with pc_write=IF_ID_write=1, imem returns 0xA,0xB,0xC -> IF_ID_inst sequence 0xA,0xB,0xC, IF_ID_pc 0,4,8, fetch_count=3, imem_addr=12.
REQ-033 At PC=8, pc_write=IF_ID_write=0 for 2 cycles -> imem_addr stays 8, IF_ID_inst/pc/valid unchanged, fetch_count unchanged; release -> next IF_ID_pc=8.
REQ-034 flush=1, redirect_pc=0x100 concurrent with pc_write=IF_ID_write=0 -> next edge imem_addr=0x100, IF_ID_inst=0x13, IF_ID_valid=0; following edge IF_ID_pc=0x100, valid=1.
REQ-035 halt pulsed one cycle at PC=0x20 -> is_halted=1, PC and fetch_count frozen 10 cycles with pc_write=1; reset -> PC=0, is_halted=0.
REQ-036 Force PC=0xFFFF_FFFC via flush, advance one cycle -> imem_addr=0x0, IF_ID_pc=0xFFFF_FFFC.
REQ-037 flush and halt on same edge with redirect_pc=0x40 -> imem_addr=0x40, IF_ID_valid=0, is_halted=1, no further change.
